// File: rtl/life_game_stepper_if.sv
// rtl/life_game_stepper_if.sv - cell RAM word-port bundle between life_game_stepper and the RAM/bus arbiter
interface life_game_stepper_if #(
    parameter int ADDR_W = 7
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/life_game_stepper.sv
// rtl/life_game_stepper.sv - in-place B3/S23 generation stepper over the life-game cell RAM
// Define LG_TORUS_EN for a wrap-around grid; otherwise cells beyond the grid are dead.
module life_game_stepper #(
    parameter int ROWS   = 64,
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [15:0]         gen_count,
    life_game_stepper_if.master mem
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW-1:0] PEN_ROW  = RW'(ROWS - 2);
    localparam logic [RW:0]   ROW_ONE  = (RW+1)'(1);
    localparam logic [RW:0]   ROW_TWO  = (RW+1)'(2);
`ifdef LG_TORUS_EN
    localparam logic [RW:0]   LAST_EXT   = (RW+1)'(ROWS - 1);
    localparam logic [2:0]    PRIME_LAST = 3'd4;
`else
    localparam logic [2:0]    PRIME_LAST = 3'd2;
`endif

    typedef enum logic [2:0] {IDLE, PRIME, FETCH, WR0, WR1, FIN} state_t;

    state_t            state, state_nx;
    logic [RW-1:0]     row;
    logic [2:0]        phase;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       prev_row, cur_row, nxt_row, next_gen, fill_row;
    logic [RW:0]       row_ext, row_p1, row_p2;
`ifdef LG_TORUS_EN
    logic [63:0]       save_row;
    assign fill_row = save_row;
`else
    assign fill_row = '0;
`endif

    assign row_ext = {1'b0, row};
    assign row_p1  = row_ext + ROW_ONE;
    assign row_p2  = row_ext + ROW_TWO;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [RW:0] r, input logic half);
        return ADDR_W'({r, half});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PRIME;
            PRIME:   if (phase == PRIME_LAST) state_nx = FETCH;
            FETCH:   if (phase == 3'd2) state_nx = WR0;
            WR0:     state_nx = WR1;
            WR1: begin
                if (row == LAST_ROW)     state_nx = FIN;
                else if (row == PEN_ROW) state_nx = WR0;
                else                     state_nx = FETCH;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != IDLE);
        done            = (state == FIN);
        mem.mem_req     = busy;
        mem.mem_we      = (state == WR0) || (state == WR1);
        mem.mem_wr_data = (state == WR1) ? next_gen[63:32] : next_gen[31:0];
    end
    assign mem.mem_addr = addr_q;

    // addr_q always holds the address the RAM port presents during the next cycle;
    // the final PRIME phase already issues row 1's first read, so row 0 enters FETCH at phase 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            phase     <= '0;
            addr_q    <= '0;
            gen_count <= '0;
            prev_row  <= '0;
            cur_row   <= '0;
            nxt_row   <= '0;
`ifdef LG_TORUS_EN
            save_row  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    row      <= '0;
                    phase    <= '0;
                    addr_q   <= '0;
                    prev_row <= '0;
                end
                PRIME: begin
                    phase <= (phase == PRIME_LAST) ? 3'd1 : phase + 3'd1;
                    case (phase)
                        3'd0: addr_q <= word_addr('0, 1'b1);
                        3'd1: begin
                            cur_row[31:0] <= mem.mem_rd_data;
`ifdef LG_TORUS_EN
                            save_row[31:0] <= mem.mem_rd_data;
                            addr_q         <= word_addr(LAST_EXT, 1'b0);
`else
                            addr_q         <= word_addr(ROW_ONE, 1'b0);
`endif
                        end
                        3'd2: begin
                            cur_row[63:32] <= mem.mem_rd_data;
`ifdef LG_TORUS_EN
                            save_row[63:32] <= mem.mem_rd_data;
                            addr_q          <= word_addr(LAST_EXT, 1'b1);
`else
                            addr_q          <= word_addr(ROW_ONE, 1'b1);
`endif
                        end
                        3'd3: begin
                            prev_row[31:0] <= mem.mem_rd_data;
                            addr_q         <= word_addr(ROW_ONE, 1'b0);
                        end
                        default: begin
                            prev_row[63:32] <= mem.mem_rd_data;
                            addr_q          <= word_addr(ROW_ONE, 1'b1);
                        end
                    endcase
                end
                FETCH: begin
                    phase <= phase + 3'd1;
                    case (phase)
                        3'd0:    addr_q <= word_addr(row_p1, 1'b1);
                        3'd1:    nxt_row[31:0] <= mem.mem_rd_data;
                        default: begin
                            nxt_row[63:32] <= mem.mem_rd_data;
                            addr_q         <= word_addr(row_ext, 1'b0);
                        end
                    endcase
                end
                WR0: addr_q <= word_addr(row_ext, 1'b1);
                WR1: begin
                    prev_row <= cur_row;
                    cur_row  <= nxt_row;
                    nxt_row  <= fill_row;
                    row      <= row + 1'b1;
                    phase    <= '0;
                    if (row == PEN_ROW)        addr_q <= word_addr(row_p1, 1'b0);
                    else if (row != LAST_ROW)  addr_q <= word_addr(row_p2, 1'b0);
                end
                FIN: gen_count <= gen_count + 16'd1;
                default: ;
            endcase
        end
    end

    // Rows padded by one cell each side: index j+1 is column j.
    always_comb begin : life_rule
        logic [65:0] pe, ce, ne;
        logic [3:0]  n;
`ifdef LG_TORUS_EN
        pe = {prev_row[0], prev_row, prev_row[63]};
        ce = {cur_row[0],  cur_row,  cur_row[63]};
        ne = {nxt_row[0],  nxt_row,  nxt_row[63]};
`else
        pe = {1'b0, prev_row, 1'b0};
        ce = {1'b0, cur_row,  1'b0};
        ne = {1'b0, nxt_row,  1'b0};
`endif
        n        = '0;
        next_gen = '0;
        for (int j = 0; j < 64; j++) begin
            n = 4'(pe[j]) + 4'(pe[j+1]) + 4'(pe[j+2]) + 4'(ce[j]) + 4'(ce[j+2])
              + 4'(ne[j]) + 4'(ne[j+1]) + 4'(ne[j+2]);
            next_gen[j] = (n == 4'd3) || (ce[j+1] && (n == 4'd2));
        end
    end
endmodule

// File: tb/tb_life_game_stepper.sv
// tb/tb_life_game_stepper.sv - directed table-driven bench for life_game_stepper with a registered RAM model
module tb_life_game_stepper;
`ifdef LG_TORUS_EN
    localparam int BUSY_EXP = 322;
    localparam int NV       = 5;
`else
    localparam int BUSY_EXP = 320;
    localparam int NV       = 4;
`endif

    typedef struct packed {
        logic [2:0]        n_init;
        logic [3:0][6:0]   init_addr;
        logic [3:0][31:0]  init_data;
        logic [1:0]        gens;
        logic [2:0]        n_exp;
        logic [3:0][6:0]   exp_addr;
        logic [3:0][31:0]  exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [15:0] gen_count;
    logic        tb_we;
    logic [6:0]  tb_addr;
    logic [31:0] tb_wdata;
    logic [31:0] ram  [128];
    logic [31:0] img  [128];
    logic [31:0] expi [128];
    vec_t        vecs [NV];
    int          checks = 0;
    int          errors = 0;
    int          exp_gen = 0;

    life_game_stepper_if #(.ADDR_W(7)) mem_bus ();

    life_game_stepper #(.ROWS(64), .ADDR_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
        .mem       (mem_bus.master)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_bus.mem_req) begin
            if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wr_data;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_wdata;
        end
        mem_bus.mem_rd_data <= ram[mem_bus.mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load_img();
        for (int w = 0; w < 128; w++) begin
            tb_we = 1'b1; tb_addr = 7'(w); tb_wdata = img[w];
            @(negedge clk);
        end
        tb_we = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        for (int w = 0; w < 128; w++)
            chk($sformatf("%s_word%0d", tag, w), {32'h0, ram[w]}, {32'h0, expi[w]});
    endtask

    // Pulses start, then counts busy cycles; optional extra start pulses at busy cycles s1/s2.
    task automatic run_gen(input int s1, input int s2, output int cyc, output int dn, output logic last_done);
        cyc = 0; dn = 0; last_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (!busy) break;
            cyc++;
            if (done) dn++;
            last_done = done;
            start = (cyc == s1) || (cyc == s2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int   cyc, dn;
        logic ld;
        rst = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;

        vecs[0] = '0; vecs[0].n_init = 1; vecs[0].gens = 1;
        vecs[0].init_addr[0] = 20; vecs[0].init_data[0] = 32'h0000_0070;
        vecs[0].n_exp = 3;
        vecs[0].exp_addr[0] = 18; vecs[0].exp_data[0] = 32'h0000_0020;
        vecs[0].exp_addr[1] = 20; vecs[0].exp_data[1] = 32'h0000_0020;
        vecs[0].exp_addr[2] = 22; vecs[0].exp_data[2] = 32'h0000_0020;

        vecs[1] = '0; vecs[1].n_init = 4; vecs[1].gens = 2; vecs[1].n_exp = 4;
        for (int i = 0; i < 4; i++) begin
            vecs[1].init_addr[i] = 7'(i);
            vecs[1].init_data[i] = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0001;
            vecs[1].exp_addr[i]  = 7'(i);
            vecs[1].exp_data[i]  = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0001;
        end

        vecs[2] = '0; vecs[2].n_init = 2; vecs[2].gens = 1; vecs[2].n_exp = 2;
        vecs[2].init_addr[0] = 0; vecs[2].init_data[0] = 32'h3;
        vecs[2].init_addr[1] = 2; vecs[2].init_data[1] = 32'h1;
        vecs[2].exp_addr[0]  = 0; vecs[2].exp_data[0]  = 32'h3;
        vecs[2].exp_addr[1]  = 2; vecs[2].exp_data[1]  = 32'h3;

        vecs[3] = '0; vecs[3].n_init = 2; vecs[3].gens = 1; vecs[3].n_exp = 2;
        vecs[3].init_addr[0] = 127; vecs[3].init_data[0] = 32'hC000_0000;
        vecs[3].init_addr[1] = 125; vecs[3].init_data[1] = 32'h8000_0000;
        vecs[3].exp_addr[0]  = 127; vecs[3].exp_data[0]  = 32'hC000_0000;
        vecs[3].exp_addr[1]  = 125; vecs[3].exp_data[1]  = 32'hC000_0000;
`ifdef LG_TORUS_EN
        vecs[4] = '0; vecs[4].n_init = 2; vecs[4].gens = 1; vecs[4].n_exp = 3;
        vecs[4].init_addr[0] = 0; vecs[4].init_data[0] = 32'h0000_0001;
        vecs[4].init_addr[1] = 1; vecs[4].init_data[1] = 32'hC000_0000;
        vecs[4].exp_addr[0] = 127; vecs[4].exp_data[0] = 32'h8000_0000;
        vecs[4].exp_addr[1] = 1;   vecs[4].exp_data[1] = 32'h8000_0000;
        vecs[4].exp_addr[2] = 3;   vecs[4].exp_data[2] = 32'h8000_0000;
`endif

        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        chk("rst_mem_we",    64'(mem_bus.mem_we), 64'd0);
        chk("rst_mem_req",   64'(mem_bus.mem_req), 64'd0);
        chk("rst_mem_addr",  64'(mem_bus.mem_addr), 64'd0);
        chk("rst_wr_data",   64'(mem_bus.mem_wr_data), 64'd0);
        chk("rst_gen_count", 64'(gen_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            for (int w = 0; w < 128; w++) begin img[w] = '0; expi[w] = '0; end
            for (int i = 0; i < 4; i++) begin
                if (i < int'(vecs[v].n_init)) img[vecs[v].init_addr[i]] = vecs[v].init_data[i];
                if (i < int'(vecs[v].n_exp))  expi[vecs[v].exp_addr[i]] = vecs[v].exp_data[i];
            end
            load_img();
            for (int g = 0; g < int'(vecs[v].gens); g++) begin
                run_gen(-1, -1, cyc, dn, ld);
                exp_gen++;
                chk($sformatf("v%0d_g%0d_busy_cycles", v, g), 64'(cyc), 64'(BUSY_EXP));
                chk($sformatf("v%0d_g%0d_done_pulses", v, g), 64'(dn), 64'd1);
                chk($sformatf("v%0d_g%0d_done_last", v, g), 64'(ld), 64'd1);
            end
            chk($sformatf("v%0d_gen_count", v), 64'(gen_count), 64'(exp_gen));
            check_ram($sformatf("v%0d", v));
        end

        repeat (3) @(negedge clk);
        chk("idle_addr_hold", 64'(mem_bus.mem_addr), 64'd127);

        for (int w = 0; w < 128; w++) begin img[w] = '0; expi[w] = '0; end
        img[20] = 32'h70; expi[18] = 32'h20; expi[20] = 32'h20; expi[22] = 32'h20;
        load_img();
        run_gen(5, 200, cyc, dn, ld);
        exp_gen++;
        repeat (4) @(negedge clk);
        chk("ignored_start_busy_cycles", 64'(cyc), 64'(BUSY_EXP));
        chk("ignored_start_done_pulses", 64'(dn), 64'd1);
        chk("ignored_start_still_idle", 64'(busy), 64'd0);
        chk("ignored_start_gen_count", 64'(gen_count), 64'(exp_gen));
        check_ram("ignored_start");

        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rst_wins_busy_later", 64'(busy), 64'd0);

        for (int w = 0; w < 128; w++) begin
            img[w]  = 32'hFFFF_FFFF;
            expi[w] = (w < 38) ? 32'h0 : 32'hFFFF_FFFF;
        end
`ifndef LG_TORUS_EN
        expi[0] = 32'h0000_0001;
        expi[1] = 32'h8000_0000;
`endif
        load_img();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",      64'(busy), 64'd0);
        chk("midrst_mem_we",    64'(mem_bus.mem_we), 64'd0);
        chk("midrst_gen_count", 64'(gen_count), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);
        check_ram("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
